// File: rtl/mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mult_pipe
// Description : Pipelined signed multiplier with valid/ready flow control.
//               The full-width product is computed in stage 1 and delayed
//               through the middle stages. The final stage rounds half toward
//               +inf, shifts arithmetically and saturates to OUT_W bits.
//               Per-sample and sticky saturation flags are provided.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_pipe #(
    parameter int A_DATA_W = 16,
    parameter int B_DATA_W = 24,
    parameter int OUT_W    = 24,
    parameter int SHIFT    = 15,
    parameter int LATENCY  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic signed [A_DATA_W-1:0] i_a,
    input  logic signed [B_DATA_W-1:0] i_b,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic signed [OUT_W-1:0]    o_c,
    output logic                       o_sat,
    output logic                       o_sat_sticky,
    input  logic                       i_clr_sat
);

    // Full product width; the extra bit in c_E_W absorbs the rounding add.
    localparam int c_P_W  = A_DATA_W + B_DATA_W;
    localparam int c_E_W  = c_P_W + 1;
    // Registers holding the product: stage 1 plus the pure delay stages.
    localparam int c_NSTG = LATENCY - 1;

    localparam logic signed [c_E_W-1:0] c_ONE = 1;
    localparam logic signed [c_E_W-1:0] c_MAX = (c_ONE <<< (OUT_W - 1)) - c_ONE;
    localparam logic signed [c_E_W-1:0] c_MIN = -(c_ONE <<< (OUT_W - 1));
    localparam logic signed [c_E_W-1:0] c_RND =
        (SHIFT > 0) ? (c_ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic signed [c_P_W-1:0] prod_q [c_NSTG];
    logic signed [c_P_W-1:0] prod_d [c_NSTG];
    logic [c_NSTG-1:0]       vld_q;
    logic [c_NSTG-1:0]       vld_d;
    logic signed [OUT_W-1:0] c_q;
    logic signed [OUT_W-1:0] c_d;
    logic                    sat_q;
    logic                    sat_d;
    logic                    out_vld_q;
    logic                    out_vld_d;
    logic                    sticky_q;
    logic                    sticky_d;

    logic                    w_en;
    logic signed [c_P_W-1:0] w_prod;
    logic signed [c_E_W-1:0] w_ext;
    logic signed [c_E_W-1:0] w_rnd;
    logic signed [c_E_W-1:0] w_shf;
    logic signed [OUT_W-1:0] w_clamped;
    logic                    w_sat;

    // The whole pipeline moves together whenever the output slot is free or being taken.
    assign w_en    = !out_vld_q || i_ready;
    assign o_ready = w_en;
    // Operands are sign-extended to the full product width before multiplying.
    assign w_prod  = c_P_W'(i_a) * c_P_W'(i_b);

    // Final-stage arithmetic: extend, round half up, shift, then clamp to OUT_W.
    always_comb begin
        w_ext     = c_E_W'(prod_q[c_NSTG-1]);
        w_rnd     = w_ext + c_RND;
        w_shf     = w_rnd >>> SHIFT;
        w_clamped = w_shf[OUT_W-1:0];
        w_sat     = 1'b0;
        if (w_shf > c_MAX) begin
            w_clamped = c_MAX[OUT_W-1:0];
            w_sat     = 1'b1;
        end else if (w_shf < c_MIN) begin
            w_clamped = c_MIN[OUT_W-1:0];
            w_sat     = 1'b1;
        end
    end

    // Next-state for every pipeline stage, the output register and the sticky flag.
    always_comb begin
        for (int i = 0; i < c_NSTG; i++) begin
            prod_d[i] = prod_q[i];
        end
        vld_d     = vld_q;
        c_d       = c_q;
        sat_d     = sat_q;
        out_vld_d = out_vld_q;
        if (w_en) begin
            prod_d[0] = w_prod;
            vld_d[0]  = i_valid;
            for (int i = 1; i < c_NSTG; i++) begin
                prod_d[i] = prod_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            c_d       = w_clamped;
            sat_d     = w_sat && vld_q[c_NSTG-1];
            out_vld_d = vld_q[c_NSTG-1];
        end
        // A clamp landing in the output register beats a clear in the same cycle.
        sticky_d = sticky_q;
        if (w_en && vld_q[c_NSTG-1] && w_sat) begin
            sticky_d = 1'b1;
        end else if (i_clr_sat) begin
            sticky_d = 1'b0;
        end
    end

    // State registers with synchronous reset that flushes all in-flight samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NSTG; i++) begin
                prod_q[i] <= '0;
            end
            vld_q     <= '0;
            c_q       <= '0;
            sat_q     <= 1'b0;
            out_vld_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            for (int i = 0; i < c_NSTG; i++) begin
                prod_q[i] <= prod_d[i];
            end
            vld_q     <= vld_d;
            c_q       <= c_d;
            sat_q     <= sat_d;
            out_vld_q <= out_vld_d;
            sticky_q  <= sticky_d;
        end
    end

    assign o_valid      = out_vld_q;
    assign o_c          = c_q;
    assign o_sat        = sat_q;
    assign o_sat_sticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_pipe
// Description : Directed self-checking bench for mult_pipe with the default
//               parameter set (16 x 24 -> 24, shift 15, latency 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_pipe;

    logic               clk;
    logic               reset;
    logic               i_valid;
    logic               o_ready;
    logic signed [15:0] i_a;
    logic signed [23:0] i_b;
    logic               o_valid;
    logic               i_ready;
    logic signed [23:0] o_c;
    logic               o_sat;
    logic               o_sat_sticky;
    logic               i_clr_sat;

    int n_checks = 0;
    int n_pass   = 0;

    mult_pipe #(
        .A_DATA_W (16),
        .B_DATA_W (24),
        .OUT_W    (24),
        .SHIFT    (15),
        .LATENCY  (3)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_a          (i_a),
        .i_b          (i_b),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_c          (o_c),
        .o_sat        (o_sat),
        .o_sat_sticky (o_sat_sticky),
        .i_clr_sat    (i_clr_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample with i_ready held high; result checked 3 edges after accept.
    task automatic run_one(input string tag, input longint a, input longint b,
                           input longint exp_c, input longint exp_sat);
        i_a     = a[15:0];
        i_b     = b[23:0];
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        step();
        check({tag, "_valid"}, longint'(o_valid), 1);
        check({tag, "_c"},     longint'(o_c),     exp_c);
        check({tag, "_sat"},   longint'(o_sat),   exp_sat);
        step();
    endtask

    int      sent;
    int      got;
    longint  rx [8];
    longint  held;
    int      stale;

    initial begin
        reset     = 1'b1;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_a       = '0;
        i_b       = '0;
        i_clr_sat = 1'b0;
        step();
        step();
        step();
        check("rst_valid",  longint'(o_valid),      0);
        check("rst_c",      longint'(o_c),          0);
        check("rst_sat",    longint'(o_sat),        0);
        check("rst_sticky", longint'(o_sat_sticky), 0);
        check("rst_ready",  longint'(o_ready),      1);
        reset = 1'b0;
        step();

        // Latency: output appears after the third edge counted from accept.
        i_a     = 16'sd16384;
        i_b     = 24'sd1000;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        check("lat_e1_valid", longint'(o_valid), 0);
        step();
        check("lat_e2_valid", longint'(o_valid), 0);
        step();
        check("lat_e3_valid", longint'(o_valid), 1);
        check("lat_c",        longint'(o_c),     500);
        check("lat_sat",      longint'(o_sat),   0);
        step();
        check("lat_drain",    longint'(o_valid), 0);

        // Rounding half toward +inf.
        run_one("rnd_pos",  1, 16384,  1, 0);
        run_one("rnd_neg",  1, -16384, 0, 0);
        run_one("rnd_neg1", 1, -16385, -1, 0);

        // Saturation at the positive corner; negative near-corner does not clamp.
        run_one("sat_pos", -32768, -8388608, 8388607, 1);
        check("sat_sticky_set", longint'(o_sat_sticky), 1);
        run_one("sat_neg", -32768, 8388607, -8388607, 0);
        check("sat_sticky_hold", longint'(o_sat_sticky), 1);

        i_clr_sat = 1'b1;
        step();
        i_clr_sat = 1'b0;
        check("clr_sticky", longint'(o_sat_sticky), 0);

        // Clear coincides with a clamp being loaded: set wins.
        i_a     = -16'sd32768;
        i_b     = -24'sd8388608;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        i_clr_sat = 1'b1;
        step();
        i_clr_sat = 1'b0;
        check("setwin_sat",    longint'(o_sat),        1);
        check("setwin_sticky", longint'(o_sat_sticky), 1);
        step();
        i_clr_sat = 1'b1;
        step();
        i_clr_sat = 1'b0;
        check("late_clr_sticky", longint'(o_sat_sticky), 0);
        step();
        check("late_clr_stays", longint'(o_sat_sticky), 0);

        // Back-pressure: 8 back-to-back samples, i_ready low for 5 cycles.
        sent = 0;
        got  = 0;
        held = 0;
        for (int c = 0; c < 40; c++) begin
            i_ready = !(c >= 5 && c < 10);
            i_valid = (sent < 8);
            i_a     = 16'(sent + 1);
            i_b     = 24'(32768 * (sent + 11));
            @(negedge clk);
            if (c == 5) held = longint'(o_c);
            if (c >= 5 && c < 10) begin
                check("bp_ready_low", longint'(o_ready), 0);
                check("bp_c_held",    longint'(o_c),     held);
            end
            if (o_valid && i_ready) begin
                if (got < 8) rx[got] = longint'(o_c);
                got++;
            end
            @(posedge clk);
            if (i_valid && o_ready) sent++;
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("bp_count", longint'(got), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bp_res%0d", k), rx[k], longint'((k + 1) * (k + 11)));
        end

        // Reset with three samples in flight (the first one clamps).
        i_valid = 1'b1;
        i_a = -16'sd32768; i_b = -24'sd8388608; step();
        i_a = 16'sd2;      i_b = 24'sd65536;    step();
        i_a = 16'sd3;      i_b = 24'sd65536;    step();
        i_valid = 1'b0;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        check("mrst_valid",  longint'(o_valid),      0);
        check("mrst_sticky", longint'(o_sat_sticky), 0);
        check("mrst_c",      longint'(o_c),          0);
        check("mrst_sat",    longint'(o_sat),        0);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (o_valid) stale++;
        end
        check("mrst_no_stale", longint'(stale), 0);
        check("mrst_sticky_after", longint'(o_sat_sticky), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
